// File: rtl/tile_reveal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_reveal_pkg
// Brief    : Shared types, frame constants and reveal-order table builder.
// Revision : 1.0
// ============================================================================
package tile_reveal_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WIPE = 1'b1
    } state_t;

    localparam int COLOR_W = 12;
    localparam int VGA_W   = 640;
    localparam int VGA_H   = 480;

    // Reveal rank of tile (col,row): 0 raster, 1 serpentine, 2 clockwise spiral.
    function automatic int tile_order(input int col, input int row,
                                      input int cols, input int rows,
                                      input int order);
        int top;
        int bot;
        int lft;
        int rgt;
        int k;
        int res;
        bit found;
        res   = 0;
        found = 1'b0;
        if (order == 0) begin
            res = row * cols + col;
        end else if (order == 1) begin
            res = (row % 2 == 0) ? (row * cols + col) : (row * cols + (cols - 1 - col));
        end else begin
            top = 0;
            bot = rows - 1;
            lft = 0;
            rgt = cols - 1;
            k   = 0;
            while (top <= bot && lft <= rgt) begin
                for (int c = lft; c <= rgt; c++) begin
                    if (!found && row == top && col == c) begin
                        res   = k;
                        found = 1'b1;
                    end
                    k++;
                end
                top++;
                for (int r = top; r <= bot; r++) begin
                    if (!found && row == r && col == rgt) begin
                        res   = k;
                        found = 1'b1;
                    end
                    k++;
                end
                rgt--;
                if (top <= bot) begin
                    for (int c = rgt; c >= lft; c--) begin
                        if (!found && row == bot && col == c) begin
                            res   = k;
                            found = 1'b1;
                        end
                        k++;
                    end
                    bot--;
                end
                if (lft <= rgt) begin
                    for (int r = bot; r >= top; r--) begin
                        if (!found && row == r && col == lft) begin
                            res   = k;
                            found = 1'b1;
                        end
                        k++;
                    end
                    lft++;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_index_map.sv
`default_nettype none
// ============================================================================
// Module   : tile_index_map
// Brief    : Maps a pixel coordinate to its tile column, in-tile x offset
//            and reveal rank.
// Revision : 1.0
// ============================================================================
module tile_index_map
    import tile_reveal_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int ROWS  = 3,
    parameter int ORDER = 2,
    localparam int N     = COLS * ROWS,
    localparam int ORD_W = $clog2(N + 1)
) (
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    output logic [9:0]       tile_col,
    output logic [9:0]       tile_x_offset,
    output logic [ORD_W-1:0] ord
);

    localparam int TILE_W = VGA_W / COLS;
    localparam int TILE_H = VGA_H / ROWS;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    logic [ORD_W-1:0] order_table [N];

    for (genvar i = 0; i < N; i++) begin : g_table
        assign order_table[i] = ORD_W'(tile_order(i % COLS, i / COLS, COLS, ROWS, ORDER));
    end

    logic [8:0]       tile_row;
    logic             in_grid;
    logic [IDX_W-1:0] idx;

    // Off-grid coordinates (blanking region) get rank N, which is never visible.
    always_comb begin
        tile_col      = x / 10'(TILE_W);
        tile_row      = y / 9'(TILE_H);
        tile_x_offset = x - tile_col * 10'(TILE_W);
        in_grid       = (tile_col < 10'(COLS)) && (tile_row < 9'(ROWS));
        idx           = in_grid ? IDX_W'(32'(tile_row) * COLS + 32'(tile_col)) : '0;
        ord           = in_grid ? order_table[idx] : ORD_W'(N);
    end

endmodule
`default_nettype wire

// File: rtl/tile_reveal_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_reveal_renderer
// Brief    : Reveals background tiles as the score rises, with a per-frame
//            left-to-right wipe and a latency-matched pixel pipeline.
// Revision : 1.0
// ============================================================================
module tile_reveal_renderer
    import tile_reveal_pkg::*;
#(
    parameter int          COLS         = 4,
    parameter int          ROWS         = 3,
    parameter int          ORDER        = 2,
    parameter int          WIPE_FRAMES  = 8,
    parameter int          MEM_LATENCY  = 2,
    parameter logic [11:0] HIDDEN_COLOR = 12'h000,
    localparam int N     = COLS * ROWS,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      score,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic             active,
    input  logic             screenEnd,
    input  logic [11:0]      pix_color,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B,
    output logic [CNT_W-1:0] shown_count,
    output logic             busy
);

    localparam int TILE_W = VGA_W / COLS;
    localparam int STEP   = TILE_W / WIPE_FRAMES;
    localparam int WC_W   = (WIPE_FRAMES > 1) ? $clog2(WIPE_FRAMES) : 1;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     shown;
    logic [CNT_W-1:0]     shown_next;
    logic [CNT_W-1:0]     target;
    logic [WC_W-1:0]      wipe_cnt;
    logic [WC_W-1:0]      cnt_next;
    logic [9:0]           wipe_col;
    logic [9:0]           col_next;
    logic [9:0]           tile_col;
    logic [9:0]           tile_x_offset;
    logic [CNT_W-1:0]     ord;
    logic                 visible;
    logic [MEM_LATENCY-1:0] vis_pipe;
    logic [MEM_LATENCY-1:0] act_pipe;
    logic [COLOR_W-1:0]   rgb;

    tile_index_map #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .ORDER (ORDER)
    ) u_map (
        .x             (x),
        .y             (y),
        .tile_col      (tile_col),
        .tile_x_offset (tile_x_offset),
        .ord           (ord)
    );

    assign target = (score > 32'(N)) ? CNT_W'(N) : score[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shown    <= '0;
            wipe_cnt <= '0;
            wipe_col <= '0;
        end else begin
            state    <= state_next;
            shown    <= shown_next;
            wipe_cnt <= cnt_next;
            wipe_col <= col_next;
        end
    end

    // Reveal state only moves at the frame boundary, so a frame never tears.
    always_comb begin
        state_next = state;
        shown_next = shown;
        cnt_next   = wipe_cnt;
        col_next   = wipe_col;
        if (screenEnd) begin
            if (target <= shown) begin
                state_next = IDLE;
                shown_next = target;
                cnt_next   = '0;
                col_next   = '0;
            end else if (state == IDLE) begin
                state_next = WIPE;
                cnt_next   = '0;
                col_next   = 10'(STEP);
            end else if (wipe_cnt == WC_W'(WIPE_FRAMES - 1)) begin
                state_next = IDLE;
                shown_next = shown + CNT_W'(1);
                cnt_next   = '0;
                col_next   = '0;
            end else begin
                cnt_next   = wipe_cnt + WC_W'(1);
                col_next   = wipe_col + 10'(STEP);
            end
        end
    end

    always_comb begin
        visible = 1'b0;
        if (tile_col < 10'(COLS)) begin
            if (ord < shown) begin
                visible = 1'b1;
            end else if (state == WIPE && ord == shown && tile_x_offset < wipe_col) begin
                visible = 1'b1;
            end
        end
    end

    // Delay visibility and active by the palette latency, then register colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis_pipe <= '0;
            act_pipe <= '0;
            rgb      <= '0;
        end else begin
            vis_pipe <= (vis_pipe << 1) | MEM_LATENCY'(visible);
            act_pipe <= (act_pipe << 1) | MEM_LATENCY'(active);
            if (!act_pipe[MEM_LATENCY-1]) begin
                rgb <= '0;
            end else if (vis_pipe[MEM_LATENCY-1]) begin
                rgb <= pix_color;
            end else begin
                rgb <= HIDDEN_COLOR;
            end
        end
    end

    assign VGA_R       = rgb[11:8];
    assign VGA_G       = rgb[7:4];
    assign VGA_B       = rgb[3:0];
    assign shown_count = shown;
    assign busy        = (state == WIPE);

endmodule
`default_nettype wire

// File: tb/tb_tile_reveal_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_reveal_renderer
// Brief    : Directed self-checking bench for tile_reveal_renderer.
// Revision : 1.0
// ============================================================================
module tb_tile_reveal_renderer;

    logic        clk;
    logic        reset;
    logic [31:0] score;
    logic [31:0] score_b;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        active;
    logic        screenEnd;
    logic [11:0] pix_color;

    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [3:0]  shown_a, shown_b;
    logic        busy_a, busy_b;
    logic [11:0] rgb_a, rgb_b;

    int n_checks = 0;
    int n_fails  = 0;

    // Default build: spiral order, 8-frame wipe.
    tile_reveal_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .score       (score),
        .x           (x),
        .y           (y),
        .active      (active),
        .screenEnd   (screenEnd),
        .pix_color   (pix_color),
        .VGA_R       (r_a),
        .VGA_G       (g_a),
        .VGA_B       (b_a),
        .shown_count (shown_a),
        .busy        (busy_a)
    );

    // Serpentine order with single-frame wipe.
    tile_reveal_renderer #(.ORDER(1), .WIPE_FRAMES(1)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .score       (score_b),
        .x           (x),
        .y           (y),
        .active      (active),
        .screenEnd   (screenEnd),
        .pix_color   (pix_color),
        .VGA_R       (r_b),
        .VGA_G       (g_b),
        .VGA_B       (b_b),
        .shown_count (shown_b),
        .busy        (busy_b)
    );

    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_b = {r_b, g_b, b_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one active pixel and return when its colour is on RGB.
    task automatic probe(input logic [9:0] px, input logic [8:0] py);
        @(negedge clk);
        x      = px;
        y      = py;
        active = 1'b1;
        repeat (3) @(negedge clk);
        active = 1'b0;
    endtask

    task automatic end_frame(input int n);
        repeat (n) begin
            @(negedge clk);
            screenEnd = 1'b1;
            @(negedge clk);
            screenEnd = 1'b0;
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        score     = 32'd0;
        score_b   = 32'd0;
        x         = '0;
        y         = '0;
        active    = 1'b0;
        screenEnd = 1'b0;
        pix_color = 12'hABC;

        repeat (3) @(negedge clk);
        check("rst_rgb", 32'(rgb_a), 32'h0);
        check("rst_shown", 32'(shown_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;

        // Score 0: everything hidden.
        end_frame(1);
        probe(10'd10, 9'd10);
        check("s0_tile0", 32'(rgb_a), 32'h000);
        probe(10'd600, 9'd400);
        check("s0_tile_last", 32'(rgb_a), 32'h000);
        check("s0_shown", 32'(shown_a), 32'd0);
        check("s0_busy", 32'(busy_a), 32'd0);

        // Score 1: tile 0 wipes in 20-pixel steps.
        score = 32'd1;
        end_frame(1);
        check("w1_busy", 32'(busy_a), 32'd1);
        probe(10'd19, 9'd5);
        check("w1_x19", 32'(rgb_a), 32'hABC);
        probe(10'd20, 9'd5);
        check("w1_x20", 32'(rgb_a), 32'h000);
        end_frame(1);
        probe(10'd39, 9'd5);
        check("w2_x39", 32'(rgb_a), 32'hABC);
        probe(10'd40, 9'd5);
        check("w2_x40", 32'(rgb_a), 32'h000);
        end_frame(6);
        check("w8_shown", 32'(shown_a), 32'd0);
        check("w8_busy", 32'(busy_a), 32'd1);
        probe(10'd159, 9'd159);
        check("w8_full", 32'(rgb_a), 32'hABC);
        end_frame(1);
        check("t0_shown", 32'(shown_a), 32'd1);
        check("t0_busy", 32'(busy_a), 32'd0);
        probe(10'd0, 9'd0);
        check("t0_origin", 32'(rgb_a), 32'hABC);
        probe(10'd160, 9'd0);
        check("t0_tile1", 32'(rgb_a), 32'h000);
        probe(10'd0, 9'd160);
        check("t0_row1", 32'(rgb_a), 32'h000);

        // Spiral vs serpentine at score 5; the serpentine build also has a 1-frame wipe.
        score   = 32'd5;
        score_b = 32'd1;
        end_frame(1);
        check("b_busy", 32'(busy_b), 32'd1);
        check("b_shown0", 32'(shown_b), 32'd0);
        probe(10'd159, 9'd0);
        check("b_wipe_full", 32'(rgb_b), 32'hABC);
        end_frame(1);
        check("b_shown1", 32'(shown_b), 32'd1);
        check("b_idle", 32'(busy_b), 32'd0);
        score_b = 32'd5;
        end_frame(36);
        check("sp_shown", 32'(shown_a), 32'd5);
        check("sp_busy", 32'(busy_a), 32'd0);
        probe(10'd480, 9'd0);
        check("sp_c3r0", 32'(rgb_a), 32'hABC);
        probe(10'd480, 9'd160);
        check("sp_c3r1", 32'(rgb_a), 32'hABC);
        check("sn_c3r1", 32'(rgb_b), 32'hABC);
        probe(10'd480, 9'd320);
        check("sp_c3r2", 32'(rgb_a), 32'h000);
        probe(10'd160, 9'd160);
        check("sp_c1r1", 32'(rgb_a), 32'h000);
        probe(10'd0, 9'd160);
        check("sn_c0r1", 32'(rgb_b), 32'h000);
        check("sn_shown", 32'(shown_b), 32'd5);

        // Decrease from 6 to 2 during the wipe of the sixth tile (col 3,row 2).
        score = 32'd6;
        end_frame(2);
        check("dec_busy_pre", 32'(busy_a), 32'd1);
        probe(10'd485, 9'd330);
        check("dec_wipe_in", 32'(rgb_a), 32'hABC);
        probe(10'd530, 9'd330);
        check("dec_wipe_out", 32'(rgb_a), 32'h000);
        score = 32'd2;
        probe(10'd480, 9'd0);
        check("dec_midframe", 32'(rgb_a), 32'hABC);
        check("dec_shown_pre", 32'(shown_a), 32'd5);
        end_frame(1);
        check("dec_shown", 32'(shown_a), 32'd2);
        check("dec_busy", 32'(busy_a), 32'd0);
        probe(10'd160, 9'd0);
        check("dec_tile1", 32'(rgb_a), 32'hABC);
        probe(10'd320, 9'd0);
        check("dec_tile2", 32'(rgb_a), 32'h000);
        probe(10'd485, 9'd330);
        check("dec_tile5", 32'(rgb_a), 32'h000);

        // Saturation: 10 more tiles at 9 frame boundaries each.
        score = 32'd100;
        end_frame(89);
        check("sat_shown11", 32'(shown_a), 32'd11);
        check("sat_busy11", 32'(busy_a), 32'd1);
        end_frame(1);
        check("sat_shown12", 32'(shown_a), 32'd12);
        check("sat_busy12", 32'(busy_a), 32'd0);
        end_frame(2);
        check("sat_hold", 32'(shown_a), 32'd12);
        check("sat_idle", 32'(busy_a), 32'd0);
        probe(10'd320, 9'd160);
        check("sat_last_tile", 32'(rgb_a), 32'hABC);

        // Latency: single-cycle colour lands on RGB three cycles after its x/y.
        @(negedge clk);
        x = 10'd10; y = 9'd10; active = 1'b1; pix_color = 12'h123;
        @(negedge clk);
        x = 10'd11;
        @(negedge clk);
        x = 10'd12; pix_color = 12'hABC;
        @(negedge clk);
        pix_color = 12'h123;
        check("lat_hit", 32'(rgb_a), 32'hABC);
        @(negedge clk);
        check("lat_next", 32'(rgb_a), 32'h123);

        // Blanking outside the active area.
        pix_color = 12'hABC;
        active    = 1'b0;
        repeat (3) @(negedge clk);
        check("blank", 32'(rgb_a), 32'h000);
        active = 1'b1;
        repeat (3) @(negedge clk);
        check("unblank", 32'(rgb_a), 32'hABC);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check("arst_rgb", 32'(rgb_a), 32'h000);
        check("arst_shown", 32'(shown_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        probe(10'd10, 9'd10);
        check("arst_refill", 32'(rgb_a), 32'h000);
        check("arst_busy", 32'(busy_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
